// File: rtl/pipe_ctrl_pkg.sv
// Shared types and control-bundle constants for the pipeline stall/flush sequencer.
package pipe_ctrl_pkg;

  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } state_t;

  typedef struct packed {
    logic pc_write;
    logic if_id_write;
    logic if_id_flush;
    logic id_ex_bubble;
    logic ex_mem_write;
    logic mem_wb_bubble;
  } ctrl_t;

  localparam int WAIT_W = 8;

  localparam ctrl_t CTRL_PASS = '{pc_write: 1'b1, if_id_write: 1'b1, if_id_flush: 1'b0,
                                  id_ex_bubble: 1'b0, ex_mem_write: 1'b1, mem_wb_bubble: 1'b0};
  localparam ctrl_t CTRL_FREEZE = '{pc_write: 1'b0, if_id_write: 1'b0, if_id_flush: 1'b0,
                                    id_ex_bubble: 1'b0, ex_mem_write: 1'b0, mem_wb_bubble: 1'b1};
  localparam ctrl_t CTRL_BUBBLE = '{pc_write: 1'b0, if_id_write: 1'b0, if_id_flush: 1'b0,
                                    id_ex_bubble: 1'b1, ex_mem_write: 1'b1, mem_wb_bubble: 1'b0};
  localparam ctrl_t CTRL_RESET = '{pc_write: 1'b0, if_id_write: 1'b0, if_id_flush: 1'b1,
                                   id_ex_bubble: 1'b1, ex_mem_write: 1'b0, mem_wb_bubble: 1'b1};

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use hazard compare between the instruction in ID and a load in EX.
module load_use_detect
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_W = 5
) (
  input  logic [REG_W-1:0] rs,
  input  logic [REG_W-1:0] rt,
  input  logic [REG_W-1:0] id_ex_rt,
  input  logic             id_ex_mem_read,
  output logic             load_use
);

  // $zero is hard-wired, so a load targeting it never creates a dependency
  assign load_use = id_ex_mem_read & (id_ex_rt != {REG_W{1'b0}}) &
                    ((rs == id_ex_rt) | (rt == id_ex_rt));

endmodule

// File: rtl/pipeline_stall_controller.sv
// Stall/flush sequencer: merges memory waits, load-use stalls and branch flushes
// into one set of pipeline-register controls, with a wait watchdog and stall counter.
module pipeline_stall_controller
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_W    = 5,
  parameter int MAX_WAIT = 15,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] Rs,
  input  logic [REG_W-1:0] Rt,
  input  logic [REG_W-1:0] ID_EX_Rt,
  input  logic             ID_EX_MemRead,
  input  logic             Branch_Taken,
  input  logic             MEM_Access,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             PCWrite,
  output logic             IF_ID_Write,
  output logic             IF_ID_Flush,
  output logic             ID_EX_Bubble,
  output logic             EX_MEM_Write,
  output logic             MEM_WB_Bubble,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cycles
);

  state_t             state_r;
  state_t             state_nxt_s;
  logic [WAIT_W-1:0]  wait_r;
  logic [WAIT_W-1:0]  wait_nxt_s;
  logic               timeout_r;
  logic               timeout_set_s;
  logic [CNT_W-1:0]   stall_r;
  logic               load_use_s;
  logic               mem_req_s;
  ctrl_t              run_ctrl_s;
  ctrl_t              ctrl_s;

  load_use_detect #(.REG_W(REG_W)) u_load_use (
    .rs             (Rs),
    .rt             (Rt),
    .id_ex_rt       (ID_EX_Rt),
    .id_ex_mem_read (ID_EX_MemRead),
    .load_use       (load_use_s)
  );

  // Controls used whenever memory is not holding the pipe: load-use beats branch flush
  always_comb begin
    run_ctrl_s = CTRL_PASS;
    if (load_use_s) begin
      run_ctrl_s = CTRL_BUBBLE;
    end else if (Branch_Taken) begin
      run_ctrl_s.if_id_flush = 1'b1;
    end else begin
      run_ctrl_s = CTRL_PASS;
    end
  end

  // Next-state, watchdog and pipeline-control decode
  always_comb begin
    mem_req_s     = MEM_Access & ~timeout_r & ~rst;
    ctrl_s        = CTRL_PASS;
    state_nxt_s   = state_r;
    wait_nxt_s    = wait_r;
    timeout_set_s = 1'b0;
    if (rst) begin
      ctrl_s = CTRL_RESET;
    end else begin
      case (state_r)
        RUN: begin
          if (mem_req_s && !mem_ready) begin
            ctrl_s      = CTRL_FREEZE;
            state_nxt_s = MEM_WAIT;
            wait_nxt_s  = {{(WAIT_W-1){1'b0}}, 1'b1};
          end else begin
            ctrl_s = run_ctrl_s;
          end
        end
        MEM_WAIT: begin
          if (mem_ready) begin
            ctrl_s      = run_ctrl_s;
            state_nxt_s = RUN;
            wait_nxt_s  = {WAIT_W{1'b0}};
          end else if (wait_r == WAIT_W'(MAX_WAIT)) begin
            // Watchdog expiry: release the pipe but drop the stuck access
            ctrl_s               = run_ctrl_s;
            ctrl_s.mem_wb_bubble = 1'b1;
            timeout_set_s        = 1'b1;
            state_nxt_s          = RUN;
            wait_nxt_s           = {WAIT_W{1'b0}};
          end else begin
            ctrl_s     = CTRL_FREEZE;
            wait_nxt_s = wait_r + {{(WAIT_W-1){1'b0}}, 1'b1};
          end
        end
        default: begin
          ctrl_s      = CTRL_RESET;
          state_nxt_s = RUN;
          wait_nxt_s  = {WAIT_W{1'b0}};
        end
      endcase
    end
  end

  // State, watchdog, sticky timeout and saturating stall counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= RUN;
      wait_r    <= {WAIT_W{1'b0}};
      timeout_r <= 1'b0;
      stall_r   <= {CNT_W{1'b0}};
    end else begin
      state_r <= state_nxt_s;
      wait_r  <= wait_nxt_s;
      if (timeout_set_s) begin
        timeout_r <= 1'b1;
      end
      if (!ctrl_s.pc_write && (stall_r != {CNT_W{1'b1}})) begin
        stall_r <= stall_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

  assign mem_req       = mem_req_s;
  assign PCWrite       = ctrl_s.pc_write;
  assign IF_ID_Write   = ctrl_s.if_id_write;
  assign IF_ID_Flush   = ctrl_s.if_id_flush;
  assign ID_EX_Bubble  = ctrl_s.id_ex_bubble;
  assign EX_MEM_Write  = ctrl_s.ex_mem_write;
  assign MEM_WB_Bubble = ctrl_s.mem_wb_bubble;
  assign mem_timeout   = timeout_r;
  assign stall_cycles  = stall_r;

endmodule

// File: doc/pipeline_stall_controller.md
Name: pipeline_stall_controller

Overview:
Central stall/flush sequencer for the 5-stage MIPS pipeline. It combines three conditions into one consistent set of pipeline-register enables and bubble/flush controls: load-use hazards detected in ID, taken branches resolved in ID, and multi-cycle data-memory accesses in MEM. It sits between the hazard/branch logic and the IF/ID, ID/EX, EX/MEM and MEM/WB registers. It owns the data-memory request handshake, a wait watchdog and a stall-cycle counter.

Parameters:
REG_W, 5, register-index width
MAX_WAIT, 15, MEM_WAIT cycles allowed before timeout (1..255)
CNT_W, 16, stall-cycle counter width

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous active-high reset
Rs  in  REG_W  source reg of instruction in ID
Rt  in  REG_W  second source reg of instruction in ID
ID_EX_Rt  in  REG_W  destination of instruction in EX
ID_EX_MemRead  in  1  instruction in EX is a load
Branch_Taken  in  1  branch/jump in ID resolved taken
MEM_Access  in  1  instruction in MEM is lw or sw
mem_ready  in  1  data memory completes the access this cycle
mem_req  out  1  data-memory request
PCWrite  out  1  PC load enable
IF_ID_Write  out  1  IF/ID load enable
IF_ID_Flush  out  1  clear IF/ID to NOP
ID_EX_Bubble  out  1  load NOP into ID/EX, active-high
EX_MEM_Write  out  1  ID/EX and EX/MEM load enable
MEM_WB_Bubble  out  1  load NOP into MEM/WB
mem_timeout  out  1  sticky error flag
stall_cycles  out  CNT_W  saturating count of stalled cycles

Behaviour:
- FSM states: RUN, MEM_WAIT. Outputs are combinational from state and inputs. mem_timeout, stall_cycles and wait_cnt are registered.
- Reset (rst=1 on a clock edge): state=RUN, wait_cnt=0, mem_timeout=0, stall_cycles=0.
- While rst=1, outputs are forced: PCWrite=0, IF_ID_Write=0, IF_ID_Flush=1, ID_EX_Bubble=1, EX_MEM_Write=0, MEM_WB_Bubble=1, mem_req=0.
- Reset asserted in MEM_WAIT abandons the access. mem_req drops in the same cycle.
- load_use = ID_EX_MemRead & (ID_EX_Rt!=0) & (Rs==ID_EX_Rt | Rt==ID_EX_Rt). Register 0 never causes a hazard.
- mem_req = MEM_Access & !mem_timeout_pending in RUN and MEM_WAIT. A transfer completes on any cycle with mem_req & mem_ready.
- Priority: memory wait > load-use > branch flush.
- RUN, MEM_Access & !mem_ready (memory stall):
  - freeze everything: PCWrite=0, IF_ID_Write=0, EX_MEM_Write=0, MEM_WB_Bubble=1, ID_EX_Bubble=0
  - Branch_Taken is ignored (re-evaluated after the freeze)
  - next state MEM_WAIT, wait_cnt=1
- RUN, load_use (no memory stall):
  - PCWrite=0, IF_ID_Write=0, ID_EX_Bubble=1, EX_MEM_Write=1, MEM_WB_Bubble=0
  - IF_ID_Flush=0 even if Branch_Taken
  - the stall lasts exactly one cycle, because the load then moves to MEM
- RUN, Branch_Taken only: PCWrite=1, IF_ID_Write=1, IF_ID_Flush=1. All other controls are in pass state.
- RUN, none of the above: all enables 1, all bubbles/flush 0, mem_req per formula. Zero-latency single-cycle memory (mem_ready=1 on the request cycle) never enters MEM_WAIT.
- MEM_WAIT:
  - freeze outputs as in the memory-stall case
  - on mem_ready: release in the same cycle with RUN-style outputs (load-use and branch evaluated), next state RUN
  - otherwise wait_cnt++
  - if wait_cnt==MAX_WAIT and !mem_ready: set mem_timeout, force release this cycle with MEM_WB_Bubble=1 (access discarded), next state RUN
- mem_timeout is cleared only by rst. While it is set, mem_req stays 0 and MEM_Access passes as a NOP (no stalls).
- stall_cycles increments on every cycle with PCWrite=0 and rst=0. It saturates at all-ones and never wraps.

Decomposition:
- Shared package pipe_ctrl_pkg holds:
  - state enum (RUN, MEM_WAIT)
  - a struct bundling the six pipeline control outputs
  - constants CTRL_PASS, CTRL_FREEZE, CTRL_BUBBLE, CTRL_RESET
- One natural sub-module, load_use_detect: purely combinational load_use compare. All other logic is inline.

Test Plan:
- lw $2 in EX (ID_EX_MemRead=1, ID_EX_Rt=2), ID Rs=2, mem_ready=1 -> exactly one cycle with PCWrite=0, IF_ID_Write=0, ID_EX_Bubble=1; stall_cycles=1 afterwards.
- ID_EX_Rt=0 with Rs=0, ID_EX_MemRead=1 -> no stall; all enables 1.
- MEM_Access=1, mem_ready low for 3 cycles then high -> mem_req high for 4 cycles; full freeze for 3 cycles; release on cycle 4; state back to RUN; stall_cycles=3.
- MEM_Access=1 with mem_ready held 0, MAX_WAIT=15 -> mem_timeout=1 after 15 wait cycles; MEM_WB_Bubble=1 on the release cycle; later MEM_Access gives mem_req=0 and no stall.
- Branch_Taken=1 together with load_use -> IF_ID_Flush=0 and stall first; on the next cycle (Branch_Taken still 1, no hazard) IF_ID_Flush=1.
- rst=1 asserted mid-MEM_WAIT -> mem_req=0 that cycle; after reset state=RUN, mem_timeout=0, stall_cycles=0; saturation check: preload counter near max, CNT_W=4, 20 stall cycles -> stall_cycles=15.
